if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Decoupling buffer between the instruction fetch stage (PC + fetched instruction) and the instruction decode stage.
- Holds up to DEPTH {pc, instr} pairs so decode stalls do not lose fetched words.
- Supports a flush on branch/jump redirect.
- Valid/ready handshake on both sides; registered outputs, no combinational path from out_ready to in_ready.

Parameters:
- XLEN, 32, width of pc and instr fields.
- DEPTH, 2, number of entries; must be a power of 2, >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  discard all held entries (redirect from branch/jump).
- in_valid  input  1  fetch presents a valid pc/instr pair.
- in_ready  output  1  queue can accept a pair this cycle.
- in_pc  input  XLEN  PC of fetched instruction.
- in_instr  input  XLEN  fetched instruction word.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes head this cycle.
- out_pc  output  XLEN  PC of head entry.
- out_instr  output  XLEN  instruction of head entry.
- out_pc_plus4  output  XLEN  out_pc + 4, truncated to XLEN (wraps 0xFFFFFFFC -> 0x00000000).
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset, asynchronous on reset falling, held while reset==0:
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_pc=0, out_instr=0, out_pc_plus4=4.
  - in_ready=1 once reset deasserts. While reset==0, in_ready=0.
  - Storage array contents need not be cleared.
- Push: in_valid && in_ready at a rising edge → entry written at wr_ptr, wr_ptr++ (mod DEPTH).
- Pop: out_valid && out_ready at a rising edge → rd_ptr++ (mod DEPTH).
- in_ready = (count < DEPTH), derived from registered count only.
  - A full queue does not accept a push in the same cycle as a pop.
  - in_ready rises the cycle after the pop.
- out_valid = (count != 0). out_pc/out_instr present the entry at rd_ptr.
- Latency:
  - A push into an empty queue appears at out_valid on the next cycle.
  - No same-cycle bypass.
- Simultaneous push and pop (0 < count < DEPTH): both pointers advance, count unchanged, ordering preserved.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointer wrap: pointers roll from DEPTH-1 to 0; FIFO order is maintained across the wrap.
- Flush (synchronous, highest priority):
  - At the edge, pointers and count go to 0.
  - Any concurrent push or pop is ignored; the pushed pair is dropped.
  - out_valid=0 from the next cycle; in_ready=1 from the next cycle.
- Flush while empty: no effect besides holding state at 0.
- in_valid low: no write, regardless of in_pc/in_instr values.
- out_ready high with out_valid low: no effect, no pointer underflow.
- Reset asserted mid-operation: all entries abandoned immediately; no partial state survives.
- Outputs on an empty queue: out_pc/out_instr may hold stale data. Decode must qualify them with out_valid. The bench checks them only when out_valid=1.

Decomposition:
- Shared package pipe_pkg:
  - XLEN constant.
  - typedef fetch_pkt_t {pc, instr}.
  - Constant INSTR_BYTES=4, used for out_pc_plus4.
- No sub-module needed; the storage array, pointers and count live in if_id_queue.
- out_pc_plus4 is a single adder on the head entry.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release → count=0, out_valid=0, in_ready=1, out_pc_plus4=4.
- Fill then drain in order:
  - Push (0x0, 0x20080005), (0x4, 0x2009000A) with out_ready=0 → count=2, in_ready=0, out_pc=0x0.
  - Raise out_ready → pops return pc 0x0 then 0x4, out_pc_plus4 0x4 then 0x8.
  - count returns to 0.
- Simultaneous push/pop: with count=1 (head pc 0x8), push pc 0xC while popping → count stays 1, next head pc=0xC.
- Wrap-around: 5 push/pop cycles of pc 0x10..0x20 → order preserved and no entry lost across pointer wrap.
- Flush with concurrent push: count=2, flush=1 and in_valid=1 (pc 0x100) in the same cycle → next cycle count=0, out_valid=0. A following push of pc 0x100 emerges as head one cycle later.
- Async reset mid-stream: with count=2, drive reset=0 between clock edges → out_valid and count go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared fetch/decode definitions: datapath width, the fetched-pair record and
// the instruction size used to form the sequential PC.
package pipe_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: holds up to DEPTH {pc, instr} pairs between fetch and
// decode, with redirect flush and a registered head entry.
module if_id_queue
  import pipe_pkg::INSTR_BYTES;
#(
  parameter int XLEN  = pipe_pkg::XLEN,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc_plus4,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  entry_t           head_q;
  entry_t           head_d;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic             push;
  logic             pop;

  // in_ready depends only on registered count and the reset pin, never on out_ready.
  assign in_ready  = reset && (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign rd_nxt    = pop ? rd_ptr + 1'b1 : rd_ptr;

  // The head register mirrors mem[rd_ptr]; a write landing on the next head slot is forwarded.
  always_comb begin
    head_d = mem[rd_nxt];
    if (push && (wr_ptr == rd_nxt)) begin
      head_d.pc    = in_pc;
      head_d.instr = in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr].pc    <= in_pc;
      mem[wr_ptr].instr <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nxt;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // Idle cycles hold the head so it never picks up uninitialised storage.
      if (push || pop) head_q <= head_d;
    end
  end

  assign out_pc       = head_q.pc;
  assign out_instr    = head_q.instr;
  assign out_pc_plus4 = head_q.pc + XLEN'(INSTR_BYTES);

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_if_id_queue;
  import pipe_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc_plus4;
  logic [CW-1:0]   count;

  int checks = 0;
  int errors = 0;

  fetch_pkt_t mq[$];

  if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_pc_plus4(out_pc_plus4), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of pairs, updated from the inputs seen at the edge.
  task automatic tick();
    bit         m_push;
    bit         m_pop;
    fetch_pkt_t p;
    m_push = reset && in_valid && (mq.size() < DEPTH) && !flush;
    m_pop  = reset && out_ready && (mq.size() != 0) && !flush;
    p.pc    = in_pc;
    p.instr = in_instr;
    @(posedge clk);
    #1;
    if (!reset) mq.delete();
    else if (flush) mq.delete();
    else begin
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(p);
    end
  endtask

  task automatic drive(input bit v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                       input bit rdy, input bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic test_reset();
    drive(0, '0, '0, 0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got %0b want 0", in_ready); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %0b want 1", in_ready); end
    tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL idle_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %0b want 0", out_valid); end
    checks++; if (out_pc_plus4 !== 32'h4) begin errors++; $display("FAIL idle_pc_plus4 got %h want 00000004", out_pc_plus4); end
  endtask

  task automatic test_fill_drain();
    drive(1, 32'h0, 32'h2008_0005, 0, 0); tick();
    drive(1, 32'h4, 32'h2009_000A, 0, 0); tick();
    drive(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL fill_count got %0d want 2", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %0b want 0", in_ready); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL fill_head_pc got %h want 00000000", out_pc); end
    checks++; if (out_instr !== 32'h2008_0005) begin errors++; $display("FAIL fill_head_instr got %h want 20080005", out_instr); end
    tick();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL stall_hold_count got %0d want 2", count); end
    out_ready = 1'b1;
    checks++; if (out_pc_plus4 !== 32'h4) begin errors++; $display("FAIL drain0_plus4 got %h want 00000004", out_pc_plus4); end
    tick();
    checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL drain1_pc got %h want 00000004", out_pc); end
    checks++; if (out_instr !== 32'h2009_000A) begin errors++; $display("FAIL drain1_instr got %h want 2009000a", out_instr); end
    checks++; if (out_pc_plus4 !== 32'h8) begin errors++; $display("FAIL drain1_plus4 got %h want 00000008", out_pc_plus4); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready got %0b want 1", in_ready); end
    tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL drain_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %0b want 0", out_valid); end
    tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL underflow_count got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    drive(1, 32'h8, 32'h1111_0008, 0, 0); tick();
    checks++; if (out_pc !== 32'h8 || count !== 2'd1) begin errors++; $display("FAIL simul_setup pc %h count %0d want 00000008 1", out_pc, count); end
    drive(1, 32'hC, 32'h1111_000C, 1, 0); tick();
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL simul_count got %0d want 1", count); end
    checks++; if (out_pc !== 32'hC) begin errors++; $display("FAIL simul_head_pc got %h want 0000000c", out_pc); end
    checks++; if (out_instr !== 32'h1111_000C) begin errors++; $display("FAIL simul_head_instr got %h want 1111000c", out_instr); end
    drive(0, '0, '0, 1, 0); tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL simul_drain got %0d want 0", count); end
    drive(1, 32'hFFFF_FFFC, 32'h0000_0013, 0, 0); tick();
    checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL plus4_wrap got %h want 00000000", out_pc_plus4); end
    drive(0, '0, '0, 1, 0); tick();
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    drive(1, 32'h10, 32'hA000_0010, 0, 0); tick();
    for (int i = 1; i < 5; i++) begin
      drive(1, 32'h10 + 32'(4 * i), 32'hA000_0010 + 32'(4 * i), 1, 0);
      tick();
      checks++;
      if (out_pc !== 32'h10 + 32'(4 * i) || count !== 2'd1) begin
        errors++; $display("FAIL wrap_head_%0d pc %h count %0d want %h 1", i, out_pc, count, 32'h10 + 32'(4 * i));
      end
    end
    drive(0, '0, '0, 1, 0); tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL wrap_final_count got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    drive(1, 32'h40, 32'h4040, 0, 0); tick();
    drive(1, 32'h44, 32'h4444, 0, 0); tick();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_setup_count got %0d want 2", count); end
    drive(1, 32'h100, 32'h0100_0100, 0, 1); tick();
    drive(0, '0, '0, 0, 0);
    checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_full count %0d valid %0b want 0 0", count, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
    drive(1, 32'h100, 32'h0100_0100, 0, 0); tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL flush_refill valid %0b pc %h want 1 00000100", out_valid, out_pc); end
    drive(1, 32'h200, 32'h0200_0200, 1, 1); tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL flush_partial_drop got %0d want 0", count); end
    drive(0, '0, '0, 0, 1); tick();
    checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty count %0d valid %0b want 0 0", count, out_valid); end
    drive(0, 32'h300, 32'h300, 0, 0); tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL no_write_when_invalid got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    drive(1, 32'h50, 32'h5050, 0, 0); tick();
    drive(1, 32'h54, 32'h5454, 0, 0); tick();
    drive(0, '0, '0, 0, 0);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL areset_setup got %0d want 2", count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_immediate count %0d valid %0b want 0 0", count, out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready got %0b want 0", in_ready); end
    checks++; if (out_pc_plus4 !== 32'h4) begin errors++; $display("FAIL areset_plus4 got %h want 00000004", out_pc_plus4); end
    mq.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    checks++; if (count !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL areset_release count %0d ready %0b want 0 1", count, in_ready); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, {$urandom(), 2'b00} , $urandom(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (count !== CW'(mq.size())) begin errors++; $display("FAIL rand_count cyc %0d got %0d want %0d", n, count, mq.size()); end
      checks++;
      if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL rand_flags cyc %0d valid %0b ready %0b size %0d", n, out_valid, in_ready, mq.size());
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_pc !== mq[0].pc || out_instr !== mq[0].instr || out_pc_plus4 !== mq[0].pc + 32'd4) begin
          errors++; $display("FAIL rand_head cyc %0d pc %h instr %h p4 %h want %h %h", n, out_pc, out_instr, out_pc_plus4, mq[0].pc, mq[0].instr);
        end
      end
    end
    drive(0, '0, '0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
